// File: rtl/decoder_rr_arbiter_if.sv
// Request/grant bundle between requesters and the shared 4-to-16 decoder arbiter.
// The requester side drives enable/req; the arbiter side returns the registered grant.
interface decoder_rr_arbiter_if #(
  parameter int IDX_W = 4
);
  localparam int N = 2 ** IDX_W;

  logic             enable;
  logic [N-1:0]     req;
  logic             grant_valid;
  logic [IDX_W-1:0] grant_idx;
  logic [N-1:0]     grant_onehot;
  logic             timeout;

  modport master (
    output enable, req,
    input  grant_valid, grant_idx, grant_onehot, timeout
  );

  modport slave (
    input  enable, req,
    output grant_valid, grant_idx, grant_onehot, timeout
  );
endinterface

// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter owning one shared line decoder; grants one requester at a time.
// Define ARB_TIMEOUT_EN to revoke an owner after MAX_HOLD consecutive grant cycles.
module decoder_rr_arbiter #(
  parameter int IDX_W    = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  decoder_rr_arbiter_if.slave  bus
);
  localparam int N = 2 ** IDX_W;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt;
  logic             vld, vld_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [N-1:0]     onehot, onehot_nxt;
  logic             tout, tout_nxt;
  logic             win_found;
  logic [IDX_W-1:0] win_idx;

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
`endif

  // First set request bit scanning upward from p and wrapping through N-1 -> 0.
  function automatic logic [IDX_W:0] rr_pick(input logic [N-1:0] r, input logic [IDX_W-1:0] p);
    logic             found;
    logic [IDX_W-1:0] w;
    logic [IDX_W-1:0] c;
    found = 1'b0;
    w     = '0;
    for (int i = 0; i < N; i++) begin
      c = p + IDX_W'(i);
      if (!found && r[c]) begin
        found = 1'b1;
        w     = c;
      end
    end
    return {found, w};
  endfunction

  always_comb begin
    {win_found, win_idx} = rr_pick(bus.req, ptr);
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    vld_nxt   = vld;
    idx_nxt   = idx;
    tout_nxt  = 1'b0;
`ifdef ARB_TIMEOUT_EN
    hold_nxt  = hold_cnt;
`endif
    case (state)
      IDLE: begin
        if (bus.enable && win_found) begin
          state_nxt = GRANT;
          vld_nxt   = 1'b1;
          idx_nxt   = win_idx;
          ptr_nxt   = win_idx + 1'b1;
`ifdef ARB_TIMEOUT_EN
          hold_nxt  = '0;
`endif
        end else begin
          vld_nxt = 1'b0;
          idx_nxt = '0;
        end
      end
      GRANT: begin
        // Release always takes priority over expiry, so no timeout pulse on a same-edge drop.
        if (!bus.req[idx]) begin
          state_nxt = IDLE;
          vld_nxt   = 1'b0;
          idx_nxt   = '0;
        end
`ifdef ARB_TIMEOUT_EN
        else if (hold_cnt == HOLD_W'(MAX_HOLD - 1)) begin
          state_nxt = IDLE;
          vld_nxt   = 1'b0;
          idx_nxt   = '0;
          tout_nxt  = 1'b1;
        end else begin
          hold_nxt = hold_cnt + 1'b1;
        end
`endif
      end
      default: begin
        state_nxt = IDLE;
        vld_nxt   = 1'b0;
        idx_nxt   = '0;
      end
    endcase
    onehot_nxt = vld_nxt ? (N'(1) << idx_nxt) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      ptr    <= '0;
      vld    <= 1'b0;
      idx    <= '0;
      onehot <= '0;
      tout   <= 1'b0;
    end else begin
      state  <= state_nxt;
      ptr    <= ptr_nxt;
      vld    <= vld_nxt;
      idx    <= idx_nxt;
      onehot <= onehot_nxt;
      tout   <= tout_nxt;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) hold_cnt <= '0;
    else       hold_cnt <= hold_nxt;
  end
`endif

  assign bus.grant_valid  = vld;
  assign bus.grant_idx    = idx;
  assign bus.grant_onehot = onehot;
  assign bus.timeout      = tout;
endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Directed bench for decoder_rr_arbiter: each step pushes the expected grant into a
// scoreboard queue; it is popped and compared once the DUT has clocked that step.
module tb_decoder_rr_arbiter;
  localparam int IDX_W = 4;
  localparam int N     = 16;

  typedef struct {
    logic             v;
    logic [IDX_W-1:0] idx;
    logic             to;
    string            tag;
  } exp_t;

  logic clk;
  logic reset;
  exp_t sb[$];
  int   tests;
  int   fails;

  decoder_rr_arbiter_if #(.IDX_W(IDX_W)) bus ();

  decoder_rr_arbiter #(.IDX_W(IDX_W), .MAX_HOLD(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_out();
    exp_t        e;
    logic [N-1:0] eoh;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL scoreboard_empty observed=0 entries expected=1");
      return;
    end
    e   = sb.pop_front();
    eoh = e.v ? (16'h0001 << e.idx) : 16'h0000;
    tests++;
    assert (bus.grant_valid === e.v) else begin
      fails++;
      $error("FAIL %s grant_valid observed=%0b expected=%0b", e.tag, bus.grant_valid, e.v);
    end
    tests++;
    assert (bus.grant_idx === e.idx) else begin
      fails++;
      $error("FAIL %s grant_idx observed=%0d expected=%0d", e.tag, bus.grant_idx, e.idx);
    end
    tests++;
    assert (bus.grant_onehot === eoh) else begin
      fails++;
      $error("FAIL %s grant_onehot observed=%h expected=%h", e.tag, bus.grant_onehot, eoh);
    end
    tests++;
    assert (bus.timeout === e.to) else begin
      fails++;
      $error("FAIL %s timeout observed=%0b expected=%0b", e.tag, bus.timeout, e.to);
    end
  endtask

  // Drive one cycle of inputs, record what the outputs must be after the next edge.
  task automatic step(input logic rst_i, input logic en, input logic [N-1:0] rq,
                      input logic ev, input logic [IDX_W-1:0] ei, input logic et,
                      input string tag);
    exp_t e;
    @(negedge clk);
    reset      = rst_i;
    bus.enable = en;
    bus.req    = rq;
    e.v   = ev;
    e.idx = ei;
    e.to  = et;
    e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    tests      = 0;
    fails      = 0;
    reset      = 1'b1;
    bus.enable = 1'b1;
    bus.req    = '0;

    // Reset state
    step(1, 1, 16'h0000, 0, 0, 0, "reset_a");
    step(1, 1, 16'h0000, 0, 0, 0, "reset_b");

    // Single requester grant and release
    step(0, 1, 16'h0001, 1, 0, 0, "single_grant");
    step(0, 1, 16'h0000, 0, 0, 0, "single_release");

    // Round robin with wrap; fresh reset so ptr starts at 0
    step(1, 1, 16'h0000, 0, 0, 0, "rr_reset");
    step(0, 1, 16'h8001, 1, 0, 0, "rr_grant0");
    step(0, 1, 16'h8001, 1, 0, 0, "rr_hold0");
    step(0, 1, 16'h8000, 0, 0, 0, "rr_turnaround0");
    step(0, 1, 16'h8001, 1, 15, 0, "rr_grant15");
    step(0, 1, 16'h0001, 0, 0, 0, "rr_turnaround15");
    step(0, 1, 16'h8001, 1, 0, 0, "rr_wrap_grant0");
    step(0, 1, 16'h0000, 0, 0, 0, "rr_idle");

    // Enable gating of new grants, not of the current owner
    for (int i = 0; i < 5; i++) step(0, 0, 16'h0010, 0, 0, 0, "enable_low");
    step(0, 1, 16'h0010, 1, 4, 0, "enable_grant4");
    step(0, 0, 16'h0010, 1, 4, 0, "enable_low_keeps_owner");
    step(0, 0, 16'h0018, 1, 4, 0, "other_req_no_effect");
    step(0, 1, 16'h0000, 0, 0, 0, "enable_release");

    // Long hold with two requesters
    step(1, 1, 16'h0000, 0, 0, 0, "hold_reset");
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < 8; i++) step(0, 1, 16'h0028, 1, 3, 0, "to_grant3");
    step(0, 1, 16'h0028, 0, 0, 1, "to_revoke3");
    for (int i = 0; i < 8; i++) step(0, 1, 16'h0028, 1, 5, 0, "to_grant5");
    step(0, 1, 16'h0028, 0, 0, 1, "to_revoke5");
    step(0, 1, 16'h0028, 1, 3, 0, "to_regrant3");
    // Release on the same edge the hold would expire: plain release
    for (int i = 0; i < 7; i++) step(0, 1, 16'h0028, 1, 3, 0, "to_hold3b");
    step(0, 1, 16'h0020, 0, 0, 0, "to_release_at_expiry");
`else
    for (int i = 0; i < 12; i++) step(0, 1, 16'h0028, 1, 3, 0, "hold_grant3");
`endif
    step(0, 1, 16'h0000, 0, 0, 0, "hold_idle");

    // Reset mid-grant clears outputs and ptr
    step(0, 1, 16'h0080, 1, 7, 0, "midreset_grant7");
    step(0, 1, 16'h0080, 1, 7, 0, "midreset_hold7");
    step(1, 1, 16'h0080, 0, 0, 0, "midreset_clear");
    step(0, 1, 16'h0081, 1, 0, 0, "midreset_ptr0");
    step(0, 1, 16'h0000, 0, 0, 0, "final_idle");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
